fp_normalize_round: RTL

- Post-add normalise/round stage. Sits directly downstream of the single-precision floating-point adder.
- Accepts the adder's raw sum: sign, larger exponent, and an unnormalised mantissa that carries a carry bit plus guard/round/sticky bits.
- Normalises the mantissa one bit per cycle, rounds to nearest-even, and packs an IEEE-754 binary32 word.
- Uses a valid/ready handshake on both sides, so it can be chained behind a registered adder.

---
 rtl/fp_normalize_round.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fp_normalize_round.sv
// Post-add normalise/round stage: takes the raw adder sum, normalises one bit
// per cycle, rounds to nearest-even and packs an IEEE-754 word.
module fp_normalize_round #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic [FRAC_W+4:0]         in_mant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     result,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned M = FRAC_W + 5;
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic [EXP_W:0]          exp_q, exp_d;
  logic [M-1:0]            mant_q, mant_d;
  logic [EXP_W+FRAC_W:0]   result_q, result_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;

  logic                    inc;
  logic [FRAC_W+1:0]       hf_sum;
  logic [EXP_W:0]          exp_rnd;
  logic [FRAC_W-1:0]       frac_rnd;

  // Rounding datapath; hf_sum = {carry, H, F} after adding the RNE increment.
  always_comb begin
    inc      = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    hf_sum   = {1'b0, mant_q[M-2:3]} + (FRAC_W+2)'(inc);
    exp_rnd  = exp_q + (EXP_W+1)'(hf_sum[FRAC_W+1]);
    frac_rnd = hf_sum[FRAC_W+1] ? hf_sum[FRAC_W:1] : hf_sum[FRAC_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = {1'b0, in_exp};
          mant_d  = in_mant;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (exp_q == EXP_MAX) begin
          result_d = {sign_q, exp_q[EXP_W-1:0], mant_q[M-3:3]};
          state_d  = DONE;
        end else if (mant_q == '0) begin
          result_d = {sign_q, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
          state_d  = DONE;
        end else if (mant_q[M-1]) begin
          // Carry: the bit falling off the bottom is folded into sticky.
          mant_d  = {1'b0, mant_q[M-1:2], mant_q[1] | mant_q[0]};
          exp_d   = exp_q + 1'b1;
          state_d = ROUND;
        end else if (mant_q[M-2]) begin
          state_d = ROUND;
        end else if (exp_q <= (EXP_W+1)'(1)) begin
          result_d = {sign_q, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
          unf_d    = 1'b1;
          state_d  = DONE;
        end else begin
          mant_d = {mant_q[M-2:0], 1'b0};
          exp_d  = exp_q - 1'b1;
        end
      end
      ROUND: begin
        if (exp_rnd >= EXP_MAX) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
